radix_4_dit_ntt_pipe: RTL and testbench
=======================================

Name: radix_4_dit_ntt_pipe

Overview:
Pipelined, parametrised radix-4 decimation-in-time NTT butterfly with a valid/ready stream interface and per-sample forward/inverse mode. It computes the same twiddled 4-point transform as the combinational radix-4 butterfly, registered over 4 stages at one butterfly per cycle. It sits between the coefficient memory read port and the write-back path of the NTT engine, and accepts backpressure from the write-back path.

Parameters:
N, 17, coefficient/twiddle width in bits; Q must satisfy Q < 2^N.
Q, 65537, prime modulus.
W4, 256, primitive 4th root of unity mod Q, so W4^2 ≡ Q-1; used in forward mode.
W4_INV, 65281, inverse of W4 mod Q, equal to Q-W4; used in inverse mode.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst  in  1  synchronous, active-high reset.
in_valid  in  1  input sample valid.
in_ready  out  1  block can accept a sample this cycle.
inv  in  1  0 selects forward (W4), 1 selects inverse (W4_INV); sampled with the data.
a0, a1, a2, a3  in  N each  input coefficients; each value < Q.
tf1, tf2, tf3  in  N each  twiddles for a1, a2, a3; each value < Q.
out_valid  out  1  output sample valid.
out_ready  in  1  downstream accepts the output.
A0, A1, A2, A3  out  N each  butterfly outputs; each value < Q.
busy  out  1  at least one pipeline stage holds a valid sample.

Behaviour:
- Maths (all mod Q):
  - b0=a0, b1=a1·tf1, b2=a2·tf2, b3=a3·tf3.
  - t0=b0+b2, t1=b0−b2, t2=b1+b3, t3=w·(b1−b3), where w=W4 if inv=0 and W4_INV if inv=1.
  - A0=t0+t2, A1=t1+t3, A2=t0−t2, A3=t1−t3.
- Width and reduction rules:
  - Products are 2N bits wide and are fully reduced to [0,Q) before they are registered.
  - Each add/sub uses an N+1-bit intermediate followed by one conditional ±Q correction.
  - Every registered value is < Q.
- Pipeline: four stages, each with its own valid bit and a registered inv bit.
  - S1 holds b0..b3.
  - S2 holds t0, t1, t2 and (b1−b3).
  - S3 holds t0, t1, t2 and t3.
  - S4 holds A0..A3, which drive the outputs directly.
- Accept on a rising edge where in_valid && in_ready. A sample accepted at edge e is presented at the outputs after edge e+3, with out_valid=1. Throughput is 1 sample per cycle.
- Stall: stall = out_valid && !out_ready.
  - in_ready = !stall.
  - While stall=1, every stage register and valid bit holds its value.
  - Bubbles are not collapsed.
  - An output transfers on an edge where out_valid && out_ready.
- When there is no stall and in_valid=0, a bubble (valid=0) enters S1. Data registers in invalid stages are don't-care, but must not propagate as valid.
- A new sample may be accepted on the same edge that an output transfers.
- inv is per sample: consecutive samples with different inv values must each use their own w.
- Reset, including mid-operation: on an edge with rst=1, all valid bits clear and in-flight samples are discarded.
  - out_valid=0, busy=0, A0..A3=0.
  - in_ready=1 in the cycle after reset.
  - rst takes priority over accept and transfer.
- busy = OR of the four stage valid bits.
- Inputs ≥ Q are out of contract; the output is unspecified but the pipeline handshake must remain correct.

Test Plan:
- Reset, then a=(1,0,0,0), tf=(5,7,9), inv=0, out_ready=1 → exactly 4 edges later A=(1,1,1,1); out_valid is high for 1 cycle.
- a=(0,1,0,0), tf1=1: with inv=0 → A=(1,256,65536,65281); with inv=1 → A=(1,65281,65536,256).
- Wrap-around: a=(65536,65536,65536,65536), tf=(1,1,1) → A=(65533,0,0,0). Also a=(1,1,1,1), tf=(1,1,1) → A=(4,0,0,0).
- Throughput and mode interleave: 8 back-to-back samples alternating inv, with out_ready=1 → 8 consecutive out_valid cycles, each output matching the golden model with the correct w.
- Backpressure: stream 6 samples and hold out_ready=0 for 3 cycles while out_valid=1 → in_ready=0 and outputs stable during the hold; all 6 outputs arrive in order with no loss or duplication.
- Reset mid-stream: assert rst for 1 cycle with 3 samples in flight → out_valid=0, busy=0 and A=0 next cycle; none of the discarded samples ever appears; the next accepted sample returns its correct result after 4 edges.

Source files
------------

// File: rtl/radix_4_dit_ntt_pipe.sv
// Pipelined radix-4 decimation-in-time NTT butterfly, one butterfly per cycle.
// Four registered stages; outputs are driven directly from stage 4.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   in_valid/in_ready         input handshake; inv selects forward (0) or inverse (1)
//   a0..a3, tf1..tf3          input coefficients and twiddles (each < Q)
//   out_valid/out_ready       output handshake
//   A0..A3                    butterfly outputs (each < Q)
//   busy                      some stage holds a valid sample
module radix_4_dit_ntt_pipe #(
   parameter int unsigned N      = 17,
   parameter int unsigned Q      = 65537,
   parameter int unsigned W4     = 256,
   parameter int unsigned W4_INV = 65281
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic         inv,
   input  logic [N-1:0] a0,
   input  logic [N-1:0] a1,
   input  logic [N-1:0] a2,
   input  logic [N-1:0] a3,
   input  logic [N-1:0] tf1,
   input  logic [N-1:0] tf2,
   input  logic [N-1:0] tf3,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] A0,
   output logic [N-1:0] A1,
   output logic [N-1:0] A2,
   output logic [N-1:0] A3,
   output logic         busy
);

   localparam int unsigned NP = 2 * N;
   localparam int unsigned NW = N + 1;
   localparam logic [NP-1:0] Q_P   = NP'(Q);
   localparam logic [NW-1:0] Q_W   = NW'(Q);
   localparam logic [N-1:0]  W_FWD = N'(W4);
   localparam logic [N-1:0]  W_INV = N'(W4_INV);

   // Full-width product reduced to [0,Q).
   function automatic logic [N-1:0] mod_mul(input logic [N-1:0] x, input logic [N-1:0] y);
      logic [NP-1:0] p;
      p = NP'(x) * NP'(y);
      return N'(p % Q_P);
   endfunction

   // N+1-bit sum with one conditional -Q correction.
   function automatic logic [N-1:0] mod_add(input logic [N-1:0] x, input logic [N-1:0] y);
      logic [NW-1:0] s;
      s = NW'(x) + NW'(y);
      if (s >= Q_W) s = s - Q_W;
      return N'(s);
   endfunction

   // N+1-bit difference; a borrow is corrected by adding Q back (modulo 2^(N+1)).
   function automatic logic [N-1:0] mod_sub(input logic [N-1:0] x, input logic [N-1:0] y);
      logic [NW-1:0] s;
      s = NW'(x) - NW'(y);
      if (x < y) s = s + Q_W;
      return N'(s);
   endfunction

   logic         v1, v2, v3, v4;
   logic         i1, i2;
   logic [N-1:0] s1_b0, s1_b1, s1_b2, s1_b3;
   logic [N-1:0] s2_t0, s2_t1, s2_t2, s2_d;
   logic [N-1:0] s3_t0, s3_t1, s3_t2, s3_t3;
   logic         stall;

   // The whole pipe freezes when the head output is not taken.
   assign stall     = v4 && !out_ready;
   assign in_ready  = !stall;
   assign out_valid = v4;
   assign busy      = v1 | v2 | v3 | v4;

   // Stage registers: S1 twiddle products, S2 first add/sub layer,
   // S3 rotation by w (chosen by the sample's own inv), S4 final layer.
   always_ff @(posedge clk) begin
      if (rst) begin
         v1 <= 1'b0;  v2 <= 1'b0;  v3 <= 1'b0;  v4 <= 1'b0;
         i1 <= 1'b0;  i2 <= 1'b0;
         s1_b0 <= '0; s1_b1 <= '0; s1_b2 <= '0; s1_b3 <= '0;
         s2_t0 <= '0; s2_t1 <= '0; s2_t2 <= '0; s2_d  <= '0;
         s3_t0 <= '0; s3_t1 <= '0; s3_t2 <= '0; s3_t3 <= '0;
         A0    <= '0; A1    <= '0; A2    <= '0; A3    <= '0;
      end else if (!stall) begin
         v1    <= in_valid;
         i1    <= inv;
         s1_b0 <= a0;
         s1_b1 <= mod_mul(a1, tf1);
         s1_b2 <= mod_mul(a2, tf2);
         s1_b3 <= mod_mul(a3, tf3);

         v2    <= v1;
         i2    <= i1;
         s2_t0 <= mod_add(s1_b0, s1_b2);
         s2_t1 <= mod_sub(s1_b0, s1_b2);
         s2_t2 <= mod_add(s1_b1, s1_b3);
         s2_d  <= mod_sub(s1_b1, s1_b3);

         v3    <= v2;
         s3_t0 <= s2_t0;
         s3_t1 <= s2_t1;
         s3_t2 <= s2_t2;
         s3_t3 <= mod_mul(i2 ? W_INV : W_FWD, s2_d);

         v4    <= v3;
         A0    <= mod_add(s3_t0, s3_t2);
         A1    <= mod_add(s3_t1, s3_t3);
         A2    <= mod_sub(s3_t0, s3_t2);
         A3    <= mod_sub(s3_t1, s3_t3);
      end
   end

endmodule

// File: tb/tb_radix_4_dit_ntt_pipe.sv
// Scoreboard bench for radix_4_dit_ntt_pipe: accepted samples push the
// reference result (direct 4-point transform) and a monitor pops on transfer.
module tb_radix_4_dit_ntt_pipe;

   localparam int unsigned N = 17;
   localparam longint      Q = 65537;

   logic         clk = 1'b0;
   logic         rst, in_valid, in_ready, inv, out_valid, out_ready, busy;
   logic [N-1:0] a0, a1, a2, a3, tf1, tf2, tf3, A0, A1, A2, A3;

   int n_checks = 0;
   int n_pass   = 0;
   logic [4*N-1:0] exp_q[$];

   always #5 clk = ~clk;

   radix_4_dit_ntt_pipe dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .inv(inv),
      .a0(a0), .a1(a1), .a2(a2), .a3(a3), .tf1(tf1), .tf2(tf2), .tf3(tf3),
      .out_valid(out_valid), .out_ready(out_ready),
      .A0(A0), .A1(A1), .A2(A2), .A3(A3), .busy(busy)
   );

   task automatic chk(input string name, input logic [127:0] got, input logic [127:0] expv);
      n_checks++;
      if (got === expv) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, got, expv);
   endtask

   // A_k = sum_j b_j * w^(j*k) mod Q, b_j = a_j * tf_j (tf_0 = 1).
   function automatic logic [4*N-1:0] model(input longint x0, x1, x2, x3,
                                            input longint t1, t2, t3, input logic m);
      longint b[4], wp[4], r[4], w;
      w = m ? 65281 : 256;
      wp[0] = 1;
      for (int i = 1; i < 4; i++) wp[i] = (wp[i-1] * w) % Q;
      b[0] = x0 % Q; b[1] = (x1 * t1) % Q; b[2] = (x2 * t2) % Q; b[3] = (x3 * t3) % Q;
      for (int k = 0; k < 4; k++) begin
         r[k] = 0;
         for (int j = 0; j < 4; j++) r[k] = (r[k] + b[j] * wp[(j * k) % 4]) % Q;
      end
      return {17'(r[0]), 17'(r[1]), 17'(r[2]), 17'(r[3])};
   endfunction

   // Monitor: decisions taken at negedge apply at the following posedge.
   always @(negedge clk) begin
      if (rst) begin
         exp_q.delete();
      end else begin
         if (out_valid && out_ready) begin
            chk("out_expected", 128'(exp_q.size() != 0), 128'(1));
            if (exp_q.size() != 0) chk("out_data", {A0, A1, A2, A3}, exp_q.pop_front());
         end
         if (in_valid && in_ready)
            exp_q.push_back(model(a0, a1, a2, a3, tf1, tf2, tf3, inv));
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic set_in(input logic [N-1:0] x0, x1, x2, x3, t1, t2, t3, input logic m);
      a0 = x0; a1 = x1; a2 = x2; a3 = x3; tf1 = t1; tf2 = t2; tf3 = t3; inv = m;
   endtask

   function automatic logic [N-1:0] rv();
      return N'($urandom_range(65536));
   endfunction

   // Present one sample from posedge+1 until accepted; ends at posedge+1.
   task automatic send(input logic [N-1:0] x0, x1, x2, x3, t1, t2, t3, input logic m);
      bit ok = 0;
      set_in(x0, x1, x2, x3, t1, t2, t3, m);
      in_valid = 1'b1;
      for (int i = 0; i < 100 && !ok; i++) begin
         @(negedge clk);
         if (in_ready) ok = 1;
      end
      if (!ok) chk("send_timeout", 128'(ok), 128'(1));
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic send_rand(input logic m);
      send(rv(), rv(), rv(), rv(), rv(), rv(), rv(), m);
   endtask

   // Single sample with fixed expected result and latency.
   task automatic directed(input string nm, input logic [N-1:0] x0, x1, x2, x3, t1, t2, t3,
                           input logic m, input logic [4*N-1:0] expv);
      int k = 0;
      send(x0, x1, x2, x3, t1, t2, t3, m);
      for (int i = 1; i <= 8 && k == 0; i++) begin
         @(negedge clk);
         if (out_valid) k = i;
      end
      chk({nm, "_latency"}, 128'(k), 128'(4));
      chk({nm, "_A"}, {A0, A1, A2, A3}, expv);
      @(negedge clk);
      chk({nm, "_pulse"}, 128'(out_valid), 128'(0));
      @(posedge clk); #1;
   endtask

   task automatic drain();
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(negedge clk);
      @(negedge clk);
      chk("drain_empty", 128'(exp_q.size()), 128'(0));
      @(posedge clk); #1;
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      set_in('0, '0, '0, '0, '0, '0, '0, 1'b0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_out_valid", 128'(out_valid), 128'(0));
      chk("rst_busy", 128'(busy), 128'(0));
      chk("rst_in_ready", 128'(in_ready), 128'(1));
      chk("rst_A", {A0, A1, A2, A3}, 128'(0));
      @(posedge clk); #1;

      directed("impulse", 17'd1, 17'd0, 17'd0, 17'd0, 17'd5, 17'd7, 17'd9, 1'b0,
               {17'd1, 17'd1, 17'd1, 17'd1});
      directed("a1_fwd", 17'd0, 17'd1, 17'd0, 17'd0, 17'd1, 17'd1, 17'd1, 1'b0,
               {17'd1, 17'd256, 17'd65536, 17'd65281});
      directed("a1_inv", 17'd0, 17'd1, 17'd0, 17'd0, 17'd1, 17'd1, 17'd1, 1'b1,
               {17'd1, 17'd65281, 17'd65536, 17'd256});
      directed("wrap", 17'd65536, 17'd65536, 17'd65536, 17'd65536, 17'd1, 17'd1, 17'd1, 1'b0,
               {17'd65533, 17'd0, 17'd0, 17'd0});
      directed("ones", 17'd1, 17'd1, 17'd1, 17'd1, 17'd1, 17'd1, 17'd1, 1'b0,
               {17'd4, 17'd0, 17'd0, 17'd0});

      // Throughput: 8 back-to-back samples alternating inv.
      fork
         for (int i = 0; i < 8; i++) send_rand(i[0]);
         begin
            int k = 0;
            for (int i = 0; i < 20 && k == 0; i++) begin
               @(negedge clk);
               if (out_valid) k = 1;
            end
            chk("tp_valid_0", 128'(out_valid), 128'(1));
            for (int i = 1; i < 8; i++) begin
               @(negedge clk);
               chk("tp_valid_n", 128'(out_valid), 128'(1));
            end
         end
      join
      drain();

      // Backpressure: 3-cycle hold while an output is presented.
      fork
         for (int i = 0; i < 6; i++) send_rand(1'($urandom_range(1)));
         begin
            logic [4*N-1:0] snap;
            int k = 0;
            for (int i = 0; i < 20 && k == 0; i++) begin
               @(negedge clk);
               if (out_valid) k = 1;
            end
            @(posedge clk); #1 out_ready = 1'b0;
            @(negedge clk);
            snap = {A0, A1, A2, A3};
            chk("bp_in_ready", 128'(in_ready), 128'(0));
            chk("bp_out_valid", 128'(out_valid), 128'(1));
            for (int i = 0; i < 2; i++) begin
               @(negedge clk);
               chk("bp_in_ready_hold", 128'(in_ready), 128'(0));
               chk("bp_A_stable", {A0, A1, A2, A3}, snap);
            end
            @(posedge clk); #1 out_ready = 1'b1;
         end
      join
      drain();

      // Reset with 3 samples in flight.
      for (int i = 0; i < 3; i++) send_rand(i[0]);
      rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      chk("mid_rst_out_valid", 128'(out_valid), 128'(0));
      chk("mid_rst_busy", 128'(busy), 128'(0));
      chk("mid_rst_in_ready", 128'(in_ready), 128'(1));
      chk("mid_rst_A", {A0, A1, A2, A3}, 128'(0));
      @(posedge clk); #1;
      directed("post_rst", 17'd0, 17'd1, 17'd0, 17'd0, 17'd1, 17'd1, 17'd1, 1'b1,
               {17'd1, 17'd65281, 17'd65536, 17'd256});
      repeat (8) @(posedge clk);
      #1;

      // Random traffic with random backpressure.
      for (int c = 0; c < 400; c++) begin
         set_in(rv(), rv(), rv(), rv(), rv(), rv(), rv(), 1'($urandom_range(1)));
         in_valid  = ($urandom_range(3) != 0);
         out_ready = ($urandom_range(3) != 0);
         @(posedge clk); #1;
      end
      drain();
      @(negedge clk);
      chk("final_idle_busy", 128'(busy), 128'(0));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
